// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment table,
// FSM state encoding and the blank pattern.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [6:0] BLANK = 7'b0000000;

    // bit6 = a ... bit0 = g, active-high
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to seven-segment lookup.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-select seven-segment display.
//   state | meaning
//   IDLE  | display blank, waiting for en with a loaded frame
//   SCAN  | digit idx driven with its decoded nibble for ON_CYC cycles
//   GAP   | all digits off for GAP_CYC cycles before the next digit
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int ON_CYC  = 16,
    parameter int GAP_CYC = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_blank_mask,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic [6:0]            o_seg_out,
    output logic                  o_frame_done,
    output logic                  o_valid
);

    localparam int IW      = $clog2(DIGITS);
    localparam int CNT_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_mask;
    logic [4*DIGITS-1:0]   r_act_data;
    logic [DIGITS-1:0]     r_act_mask;
    logic                  r_valid;
    logic [DIGITS-1:0]     r_digit_sel;
    logic [6:0]            r_seg_out;
    logic                  r_frame_done;

    state_t                w_state_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_reload;
    logic [4*DIGITS-1:0]   w_act_data_nxt;
    logic [DIGITS-1:0]     w_act_mask_nxt;
    logic [3:0]            w_nib;
    logic [6:0]            w_dec;
    logic [DIGITS-1:0]     w_sel_nxt;
    logic [6:0]            w_seg_nxt;
    logic                  w_fd_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_reload    = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_valid || i_load) begin
                        w_state_nxt = SCAN;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_reload    = 1'b1;
                    end
                end
                SCAN: begin
                    if (r_cnt == CW'(ON_CYC - 1)) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == CW'(GAP_CYC - 1)) begin
                        w_state_nxt = SCAN;
                        w_cnt_nxt   = '0;
                        if (r_idx == IW'(DIGITS - 1)) begin
                            w_idx_nxt = '0;
                            w_reload  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A load on the reload edge bypasses pending so it shows in this frame.
    assign w_act_data_nxt = w_reload ? (i_load ? i_data : r_pend_data) : r_act_data;
    assign w_act_mask_nxt = w_reload ? (i_load ? i_blank_mask : r_pend_mask) : r_act_mask;
    assign w_nib          = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];

    seg_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // Outputs are computed from the next state so they change on state entry.
    always_comb begin
        w_sel_nxt = '0;
        w_seg_nxt = BLANK;
        w_fd_nxt  = 1'b0;
        if (w_state_nxt == SCAN) begin
            w_sel_nxt = DIGITS'(1) << w_idx_nxt;
            w_seg_nxt = w_act_mask_nxt[w_idx_nxt] ? BLANK : w_dec;
        end
        if ((w_state_nxt == GAP) && (w_idx_nxt == IW'(DIGITS - 1)) &&
            (w_cnt_nxt == CW'(GAP_CYC - 1))) begin
            w_fd_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_data  <= '0;
            r_pend_mask  <= '0;
            r_act_data   <= '0;
            r_act_mask   <= '0;
            r_valid      <= 1'b0;
            r_digit_sel  <= '0;
            r_seg_out    <= BLANK;
            r_frame_done <= 1'b0;
        end else begin
            if (i_load) begin
                r_pend_data <= i_data;
                r_pend_mask <= i_blank_mask;
            end
            r_act_data   <= w_act_data_nxt;
            r_act_mask   <= w_act_mask_nxt;
            r_valid      <= r_valid | i_load;
            r_digit_sel  <= w_sel_nxt;
            r_seg_out    <= w_seg_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign o_digit_sel  = r_digit_sel;
    assign o_seg_out    = r_seg_out;
    assign o_frame_done = r_frame_done;
    assign o_valid      = r_valid;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int DIGITS  = 4;
    localparam int ON_CYC  = 4;
    localparam int GAP_CYC = 1;
    localparam int DPER    = ON_CYC + GAP_CYC;
    localparam int FPER    = DIGITS * DPER;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  mask;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_out;
    logic        frame_done;
    logic        valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_ref [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // reference model: running flag plus position within the frame
    logic        m_run;
    int          m_pos;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pmask, m_amask;
    logic        m_valid;

    seg_scan_ctrl #(.DIGITS(DIGITS), .ON_CYC(ON_CYC), .GAP_CYC(GAP_CYC)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_load       (load),
        .i_data       (data),
        .i_blank_mask (mask),
        .o_digit_sel  (digit_sel),
        .o_seg_out    (seg_out),
        .o_frame_done (frame_done),
        .o_valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_pend = '0; m_act = '0;
        m_pmask = '0; m_amask = '0; m_valid = 0;
    endtask

    task automatic model_edge(input logic e, input logic l, input logic [15:0] d, input logic [3:0] mk);
        if (!e) begin
            m_run = 0;
        end else if (!m_run) begin
            if (m_valid || l) begin
                m_run = 1; m_pos = 0;
                m_act = l ? d : m_pend; m_amask = l ? mk : m_pmask;
            end
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == FPER) begin
                m_pos = 0;
                m_act = l ? d : m_pend; m_amask = l ? mk : m_pmask;
            end
        end
        if (l) begin
            m_pend = d; m_pmask = mk;
        end
        m_valid = m_valid | l;
    endtask

    task automatic check_outputs();
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        logic       e_fd;
        int         dig;
        e_sel = '0; e_seg = '0; e_fd = 0;
        if (m_run) begin
            dig = m_pos / DPER;
            if ((m_pos % DPER) < ON_CYC) begin
                e_sel = 4'(1 << dig);
                e_seg = m_amask[dig] ? 7'b0 : seg_ref[(m_act >> (4 * dig)) & 16'hF];
            end
            e_fd = (m_pos == FPER - 1);
        end
        check("digit_sel", 32'(digit_sel), 32'(e_sel));
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("valid", 32'(valid), 32'(m_valid));
        check("onehot", 32'($countones(digit_sel) <= 1), 32'd1);
    endtask

    task automatic cyc(input logic e, input logic l, input logic [15:0] d, input logic [3:0] mk);
        en = e; load = l; data = d; mask = mk;
        @(posedge clk);
        model_edge(e, l, d, mk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'(($urandom)), 4'($urandom));
    endtask

    task automatic run_to(input int p);
        logic hit;
        hit = 0;
        for (int i = 0; i < 2 * FPER && !hit; i++) begin
            if (m_run && m_pos == p) hit = 1;
            else cyc(1'b1, 1'b0, 16'h0, 4'h0);
        end
        check("run_to_reached", 32'(hit), 32'd1);
    endtask

    initial begin
        rst = 1; en = 0; load = 0; data = '0; mask = '0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk); #1;
        rst = 0;

        // idle with en high but nothing loaded
        run(10);

        // first frame: 4321
        cyc(1, 1, 16'h4321, 4'b0000);
        run(24);

        // two mid-frame loads, last one wins at the boundary
        run_to(3);
        cyc(1, 1, 16'hFEDC, 4'b0000);
        run(5);
        cyc(1, 1, 16'h8888, 4'b0000);
        run(2 * FPER);

        // load on the frame_done cycle takes effect immediately
        run_to(FPER - 1);
        cyc(1, 1, 16'hA5C3, 4'b0000);
        run(FPER);

        // masked digits keep their timing
        run_to(FPER - 1);
        cyc(1, 1, 16'h1357, 4'b1010);
        run(FPER + 3);

        // en drop mid-scan, then resume at digit 0
        run_to(DPER + 2);
        cyc(0, 0, 16'h0, 4'h0);
        cyc(0, 0, 16'h0, 4'h0);
        cyc(0, 0, 16'h0, 4'h0);
        run(FPER + 2);

        // async reset mid-scan clears outputs without a clock edge
        run_to(2);
        rst = 1;
        #1;
        model_reset();
        check_outputs();
        #2;
        rst = 0;
        run(12);

        // sweep all nibbles on digit 0
        cyc(1, 1, 16'h0000, 4'b0000);
        for (int v = 0; v < 16; v++) begin
            run_to(FPER - 1);
            cyc(1, 1, {12'($urandom), 4'(v)}, 4'b0000);
            run(2);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
                16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-select seven-segment display. Holds a frame of hex nibbles, steps one digit at a time through a shared hex-to-segment decoder, and drives a one-hot digit select with a blanking gap between digits to prevent ghosting. It sits between the register or counter logic producing display values and the display pins. New frames are applied only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned (2..8)
- ON_CYC, 16: cycles each digit is driven (>=1)
- GAP_CYC, 2: blank cycles after each digit (>=1)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  scan enable; low forces blank idle
- load  input  1  one-cycle strobe: capture data and blank_mask
- data  input  4*DIGITS  nibble i = data[4i+3:4i] for digit i
- blank_mask  input  DIGITS  bit i set: digit i shows no segments
- digit_sel  output  DIGITS  one-hot active-high digit drive, registered
- seg_out  output  7  segment pattern, bit6=a … bit0=g, active-high, registered
- frame_done  output  1  one-cycle pulse at end of the last digit's gap
- valid  output  1  high once any frame has been loaded since reset

## Operation
- Registers: pending (data + mask), active (data + mask), state, digit index idx (0..DIGITS-1), cycle counter cnt.
- load writes pending every cycle it is high, regardless of state. valid is set on the first load and cleared only by rst.
- States:
  - IDLE: outputs blank.
  - SCAN: digit_sel = 1<<idx; seg_out = decode(active nibble idx), or 0 if the mask bit is set.
  - GAP: digit_sel = 0, seg_out = 0.
- Transitions:
  - IDLE→SCAN: when en is high and valid is high, or load is high this cycle. idx = 0 and cnt = 0. active takes the load inputs if load is high, otherwise pending.
  - SCAN→GAP: after ON_CYC cycles.
  - GAP→SCAN: after GAP_CYC cycles, with idx+1.
  - Last digit: GAP of idx = DIGITS-1 ends with frame_done, idx wraps to 0, and active reloads.
- Frame-boundary reload: active ← (load ? inputs : pending), so a load coincident with the boundary takes effect immediately.
- en low in any state: next edge goes to IDLE and outputs blank. pending, active and valid are retained. Re-enabling restarts at digit 0 with the boundary reload rule.
- Decoder table, 0–F:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001
  - 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1111011, A 1110111, b 0011111
  - C 1001110, d 0111101, E 1001111, F 1000111
  - All 16 codes are defined; there is no latch or default hole.

## Timing
- Reset values: digit_sel = 0, seg_out = 0, frame_done = 0, valid = 0, state = IDLE, pending = active = 0.
- Outputs are flops loaded on the same edge the FSM enters a state. There is no combinational path from inputs to outputs.
- Latency: load in cycle t while IDLE and en high → digit 0 driven from edge t+1.
- Digit period is ON_CYC+GAP_CYC cycles; frame period is DIGITS·(ON_CYC+GAP_CYC). Two digit_sel bits are never high together, and no digit is ever adjacent to another without a gap.
- frame_done is high for exactly the last GAP cycle of digit DIGITS-1.
- rst asserted mid-scan clears all outputs immediately (asynchronously). After release, the block waits in IDLE for a load.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry segment constant table;
  - the state enum (IDLE, SCAN, GAP);
  - the BLANK = 7'b0 constant.
- Sub-module seg_decoder: purely combinational 4-bit → 7-bit lookup using the seg_pkg table. seg_scan_ctrl instantiates it once and registers its output.
- Counters are sized $clog2 of their maxima and saturate-free; wrap is by explicit compare.

## Test plan
Bench configuration: DIGITS=4, ON_CYC=4, GAP_CYC=1.
- Reset, then idle with en=1 and no load → digit_sel=0 and seg_out=0 indefinitely, valid=0.
- load data=16'h4321, mask=0, en=1 → next edge digit_sel=0001 with seg_out=0110000 for 4 cycles, then 1 blank cycle, then digit_sel=0010 with seg_out=1101101. frame_done pulses on cycle 20.
- Mid-frame load data=16'hFEDC, then later load 16'h8888 before the boundary → the current frame completes unchanged, and the next frame shows 1111111 on all digits (the last pending wins).
- Load coincident with the frame_done cycle → the new value is shown starting with digit 0 of the next frame.
- mask=4'b1010 → digits 1 and 3 are selected with seg_out=0, and their timing is unchanged.
- en dropped mid-SCAN, then rst pulsed mid-SCAN → blank at the next edge (en) or immediately (rst). After en returns, the scan restarts at digit 0. After rst, valid=0 and the block stays idle until a load.
- Sweep all 16 nibbles on digit 0 → each matches the table; one-hot select is checked every cycle.
